// File: rtl/video_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : video_frame_sequencer
// Brief    : Frames a free-running pixel source into Avalon-ST packets through
//            a small show-ahead FIFO that drops pixels on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module video_frame_sequencer #(
    parameter int H_ACTIVE   = 320,
    parameter int V_ACTIVE   = 240,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        enable,
    input  logic        frame_start,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic [23:0] src_data,
    output logic        src_startofpacket,
    output logic        src_endofpacket,
    output logic        src_valid,
    input  logic        src_ready,
    output logic        busy,
    output logic        overflow,
    input  logic        clear_overflow,
    output logic [15:0] frame_count
);

    localparam int c_TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int c_CW    = $clog2(c_TOTAL + 1);
    localparam int c_AW    = $clog2(FIFO_DEPTH);

    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_TOTAL - 1);
    localparam logic [c_AW:0]   c_THR  = (c_AW + 1)'(FIFO_DEPTH - 1);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ARMED  = 2'd1;
    localparam logic [1:0] c_S_STREAM = 2'd2;
    localparam logic [1:0] c_S_DRAIN  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_CW-1:0] r_pix_cnt;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [25:0]     r_mem [FIFO_DEPTH];
    logic            r_overflow;
    logic [15:0]     r_frame_cnt;

    logic            w_start;
    logic            w_pix_in;
    logic [c_CW-1:0] w_idx;
    logic            w_sop;
    logic            w_eop;
    logic            w_valid;
    logic            w_pop;
    logic [c_AW:0]   w_occ;
    logic            w_drop;
    logic            w_push;
    logic            w_frame_done;
    logic [25:0]     w_head;

    // The pixel arriving alongside frame_start is index 0 of the new frame.
    assign w_start  = (r_state == c_S_ARMED) && enable && frame_start;
    assign w_pix_in = pix_valid && (w_start || (r_state == c_S_STREAM));
    assign w_idx    = (r_state == c_S_ARMED) ? '0 : r_pix_cnt;
    assign w_sop    = (w_idx == '0);
    assign w_eop    = (w_idx == c_LAST);

    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid && src_ready;
    assign w_occ    = r_count - {{c_AW{1'b0}}, w_pop};
    // One slot stays reserved so the end-of-packet pixel is never lost.
    assign w_drop   = w_pix_in && !w_eop && (w_occ >= c_THR);
    assign w_push   = w_pix_in && !w_drop;

    assign w_frame_done = (r_state == c_S_DRAIN) && (r_count == '0);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (enable) w_state_nxt = c_S_ARMED;
            end
            c_S_ARMED: begin
                if (!enable) begin
                    w_state_nxt = c_S_IDLE;
                end else if (frame_start) begin
                    w_state_nxt = (w_pix_in && w_eop) ? c_S_DRAIN : c_S_STREAM;
                end
            end
            c_S_STREAM: begin
                if (w_pix_in && w_eop) w_state_nxt = c_S_DRAIN;
            end
            c_S_DRAIN: begin
                if (r_count == '0) w_state_nxt = enable ? c_S_ARMED : c_S_IDLE;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_pix_cnt <= '0;
        end else if (w_pix_in) begin
            r_pix_cnt <= w_idx + c_CW'(1);
        end else if ((r_state == c_S_IDLE) || (r_state == c_S_ARMED)) begin
            r_pix_cnt <= '0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {w_sop, w_eop, pix_data};
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_overflow  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
            if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // Head entry is masked so stale memory never reaches the bus after reset.
    assign w_head            = w_valid ? r_mem[r_rd_ptr] : '0;
    assign src_valid         = w_valid;
    assign src_data          = w_head[23:0];
    assign src_endofpacket   = w_head[24];
    assign src_startofpacket = w_head[25];
    assign busy              = (r_state == c_S_STREAM) || (r_state == c_S_DRAIN);
    assign overflow          = r_overflow;
    assign frame_count       = r_frame_cnt;

endmodule
`default_nettype wire
